// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the Fetch-stage sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_HOLD      = 3'd2,
    ST_BR_SHADOW = 3'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_ZERO   = 2'd0,
    PC_SEL_INC    = 2'd1,
    PC_SEL_HOLD   = 2'd2,
    PC_SEL_BRANCH = 2'd3
  } pc_sel_e;

  localparam int PC_INC       = 4;
  localparam int SHADOW_CNT_W = 8;  // holds BR_TIMEOUT-1 for timeouts up to 255

endpackage

// File: rtl/fetch_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Advances on the falling clock edge so it stays in step with the Fetch stage.
module fetch_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: next-PC select, IR hold, fetch-valid and
// branch-shadow watchdog. Optional perf counters built with FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = 16,
  parameter int BR_TIMEOUT = 15,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic                 I_LOCK,
  input  logic [PC_WIDTH-1:0]  I_CurPC,
  input  logic [PC_WIDTH-1:0]  I_BranchPC,
  input  logic                 I_BranchAddrSelect,
  input  logic                 I_BranchStallSignal,
  input  logic                 I_DepStallSignal,
  input  logic                 I_GPUStallSignal,
  output logic [PC_WIDTH-1:0]  O_NextPC,
  output logic [1:0]           O_PCSel,
  output logic                 O_IRHold,
  output logic                 O_FE_Valid,
  output logic [2:0]           O_State,
  output logic                 O_BranchTimeout,
  output logic [CNT_WIDTH-1:0] O_StallCycles,
  output logic [CNT_WIDTH-1:0] O_BubbleCycles
);

  localparam logic [SHADOW_CNT_W-1:0] SHADOW_LAST = SHADOW_CNT_W'(BR_TIMEOUT - 1);

  fetch_state_e            state_q, state_d;
  logic [SHADOW_CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;
  logic                    timeout_q, timeout_d;
  pc_sel_e                 pc_sel;
  logic                    ir_hold;
  logic                    fe_valid;
  logic                    pipe_stall;

  assign pipe_stall = I_DepStallSignal | I_GPUStallSignal;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred. The shadow counter defaults to
  // zero, which also clears it on every entry into BR_SHADOW.
  always_comb begin
    state_d      = state_q;
    shadow_cnt_d = '0;
    timeout_d    = timeout_q;
    pc_sel       = PC_SEL_ZERO;
    ir_hold      = 1'b0;
    fe_valid     = 1'b0;

    if (!I_LOCK) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN, ST_HOLD: begin
          if (I_BranchAddrSelect) begin
            pc_sel   = PC_SEL_BRANCH;
            fe_valid = 1'b1;
            state_d  = ST_RUN;
          end else if (pipe_stall) begin
            pc_sel   = PC_SEL_HOLD;
            ir_hold  = 1'b1;
            fe_valid = 1'b1;
            state_d  = ST_HOLD;
          end else if (I_BranchStallSignal) begin
            pc_sel  = PC_SEL_HOLD;
            state_d = ST_BR_SHADOW;
          end else begin
            pc_sel   = PC_SEL_INC;
            fe_valid = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_BR_SHADOW: begin
          // The redirect cycle out of the shadow is itself a bubble.
          if (I_BranchAddrSelect) begin
            pc_sel  = PC_SEL_BRANCH;
            state_d = ST_RUN;
          end else if (shadow_cnt_q == SHADOW_LAST) begin
            timeout_d = 1'b1;
            pc_sel    = PC_SEL_INC;
            fe_valid  = 1'b1;
            state_d   = ST_RUN;
          end else begin
            shadow_cnt_d = shadow_cnt_q + SHADOW_CNT_W'(1);
            pc_sel       = PC_SEL_HOLD;
            ir_hold      = pipe_stall;
            fe_valid     = pipe_stall;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q      <= ST_IDLE;
      shadow_cnt_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_cnt_q <= shadow_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    O_NextPC = '0;
    unique case (pc_sel)
      PC_SEL_ZERO:   O_NextPC = '0;
      PC_SEL_INC:    O_NextPC = I_CurPC + PC_WIDTH'(PC_INC);
      PC_SEL_HOLD:   O_NextPC = I_CurPC;
      PC_SEL_BRANCH: O_NextPC = I_BranchPC;
      default:       O_NextPC = '0;
    endcase
  end

  assign O_PCSel         = pc_sel;
  assign O_IRHold        = ir_hold;
  assign O_FE_Valid      = fe_valid;
  assign O_State         = state_q;
  assign O_BranchTimeout = timeout_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (I_CLOCK),
    .clr_n (I_RESET_N),
    .en    (state_q == ST_HOLD),
    .count (O_StallCycles)
  );

  fetch_sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (I_CLOCK),
    .clr_n (I_RESET_N),
    .en    (I_LOCK && !fe_valid),
    .count (O_BubbleCycles)
  );
`else
  assign O_StallCycles  = '0;
  assign O_BubbleCycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random stimulus, all checked
// against a rule-level reference model of the Fetch sequencing behaviour.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int PW  = 16;
  localparam int BRT = 15;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lock, redir, br_stall, dep_stall, gpu_stall;
  logic [PW-1:0] cur_pc, br_pc;
  logic [PW-1:0] next_pc;
  logic [1:0]    pc_sel;
  logic          ir_hold, fe_valid, br_timeout;
  logic [2:0]    state;
  logic [CW-1:0] stall_cycles, bubble_cycles;

  fetch_ctrl #(.PC_WIDTH(PW), .BR_TIMEOUT(BRT), .CNT_WIDTH(CW)) dut (
    .I_CLOCK             (clk),
    .I_RESET_N           (rst_n),
    .I_LOCK              (lock),
    .I_CurPC             (cur_pc),
    .I_BranchPC          (br_pc),
    .I_BranchAddrSelect  (redir),
    .I_BranchStallSignal (br_stall),
    .I_DepStallSignal    (dep_stall),
    .I_GPUStallSignal    (gpu_stall),
    .O_NextPC            (next_pc),
    .O_PCSel             (pc_sel),
    .O_IRHold            (ir_hold),
    .O_FE_Valid          (fe_valid),
    .O_State             (state),
    .O_BranchTimeout     (br_timeout),
    .O_StallCycles       (stall_cycles),
    .O_BubbleCycles      (bubble_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode numbers are the documented state codes.
  int          m_mode, m_age;
  bit          m_flag;
  longint      m_stall, m_bubble;
  int          e_sel, e_next;
  bit          e_ir, e_val, e_flag_set;
  longint      e_npc;
  logic [PW-1:0] tb_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat_inc(input longint v);
    longint lim = (longint'(1) << CW) - 1;
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_flag = 0; m_stall = 0; m_bubble = 0; tb_pc = '0;
  endtask

  task automatic model_eval();
    bit stall = dep_stall || gpu_stall;
    e_sel = 0; e_ir = 0; e_val = 0; e_next = 0; e_flag_set = 0;
    if (lock) begin
      if (m_mode == 0) e_next = 1;
      else if (m_mode == 3) begin
        if (redir) begin e_sel = 3; e_next = 1; end
        else if (m_age + 1 >= BRT) begin e_sel = 1; e_val = 1; e_next = 1; e_flag_set = 1; end
        else begin e_sel = 2; e_ir = stall; e_val = stall; e_next = 3; end
      end else begin
        if (redir)         begin e_sel = 3; e_val = 1; e_next = 1; end
        else if (stall)    begin e_sel = 2; e_ir = 1; e_val = 1; e_next = 2; end
        else if (br_stall) begin e_sel = 2; e_next = 3; end
        else               begin e_sel = 1; e_val = 1; e_next = 1; end
      end
    end
    case (e_sel)
      1:       e_npc = (longint'(cur_pc) + 4) % (longint'(1) << PW);
      2:       e_npc = longint'(cur_pc);
      3:       e_npc = longint'(br_pc);
      default: e_npc = 0;
    endcase
  endtask

  task automatic model_commit();
    if (m_mode == 2) m_stall = sat_inc(m_stall);
    if (lock && !e_val) m_bubble = sat_inc(m_bubble);
    if (e_flag_set) m_flag = 1;
    m_age  = (m_mode == 3 && e_next == 3) ? m_age + 1 : 0;
    m_mode = e_next;
    tb_pc  = PW'(e_npc);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_state"}, 64'(state), 64'(m_mode));
    check({tag, "_tmo"}, 64'(br_timeout), 64'(m_flag));
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_stallcnt"}, 64'(stall_cycles), 64'(m_stall));
    check({tag, "_bubcnt"}, 64'(bubble_cycles), 64'(m_bubble));
`else
    check({tag, "_stallcnt"}, 64'(stall_cycles), 64'd0);
    check({tag, "_bubcnt"}, 64'(bubble_cycles), 64'd0);
`endif
  endtask

  // Drive one cycle's inputs mid-cycle and compare the Mealy outputs.
  task automatic apply(input bit l, input bit rd, input logic [PW-1:0] bp, input bit b,
                       input bit d, input bit g, input logic [PW-1:0] cp);
    @(posedge clk);
    lock = l; redir = rd; br_pc = bp; br_stall = b; dep_stall = d; gpu_stall = g; cur_pc = cp;
    #1;
    model_eval();
    check("sel", 64'(pc_sel), 64'(e_sel));
    check("npc", 64'(next_pc), 64'(e_npc));
    check("irhold", 64'(ir_hold), 64'(e_ir));
    check("valid", 64'(fe_valid), 64'(e_val));
    check("state_pre", 64'(state), 64'(m_mode));
  endtask

  task automatic advance();
    @(negedge clk);
    model_commit();
    #1;
    check_regs("post");
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1, 0, '0, 0, 0, 0, tb_pc);
      advance();
    end
  endtask

  logic [CW-1:0] bub_before;

  initial begin
    rst_n = 1'b0; lock = 0; redir = 0; br_stall = 0; dep_stall = 0; gpu_stall = 0;
    cur_pc = '0; br_pc = '0;
    model_reset();
    #12;
    check("rst_npc", 64'(next_pc), 64'd0);
    check("rst_sel", 64'(pc_sel), 64'd0);
    check("rst_valid", 64'(fe_valid), 64'd0);
    check_regs("rst");
    rst_n = 1'b1;

    // First fetch: one IDLE cycle, then sequential increments from 0.
    apply(1, 0, '0, 0, 0, 0, tb_pc); advance();
    apply(1, 0, '0, 0, 0, 0, tb_pc); check("seq_npc1", 64'(next_pc), 64'h4); advance();
    apply(1, 0, '0, 0, 0, 0, tb_pc); check("seq_npc2", 64'(next_pc), 64'h8); advance();
    apply(1, 0, '0, 0, 0, 0, tb_pc); check("seq_npc3", 64'(next_pc), 64'hC);
    check("seq_sel", 64'(pc_sel), 64'(PC_SEL_INC)); advance();
    run_plain(1);

    // Dependency stall at 0x0010 for three cycles.
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, '0, 0, 1, 0, tb_pc);
      check("dep_npc", 64'(next_pc), 64'h10);
      check("dep_ir", 64'(ir_hold), 64'd1);
      advance();
    end
    apply(1, 0, '0, 0, 0, 0, tb_pc); check("dep_rel_npc", 64'(next_pc), 64'h14); advance();
    check("dep_rel_state", 64'(state), 64'(ST_RUN));
    run_plain(3);

    // Branch stall at 0x0020 then redirect to 0x0100.
    bub_before = bubble_cycles;
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, '0, 1, 0, 0, tb_pc);
      check("bsh_valid", 64'(fe_valid), 64'd0);
      check("bsh_npc", 64'(next_pc), 64'h20);
      advance();
    end
    apply(1, 1, 16'h0100, 1, 0, 0, tb_pc);
    check("bsh_redir_npc", 64'(next_pc), 64'h100);
    check("bsh_redir_sel", 64'(pc_sel), 64'(PC_SEL_BRANCH));
    advance();
`ifdef FETCH_PERF_CNT_EN
    check("bsh_bubbles", 64'(bubble_cycles - bub_before), 64'd4);
`endif

    // Watchdog: shadow held with no redirect.
    apply(1, 0, '0, 1, 0, 0, tb_pc); advance();
    for (int i = 1; i <= BRT; i++) begin
      apply(1, 0, '0, 1, 0, 0, tb_pc);
      check("wd_sel", 64'(pc_sel), (i == BRT) ? 64'(PC_SEL_INC) : 64'(PC_SEL_HOLD));
      advance();
      check("wd_flag", 64'(br_timeout), (i == BRT) ? 64'd1 : 64'd0);
    end
    check("wd_state", 64'(state), 64'(ST_RUN));
    apply(0, 0, '0, 0, 0, 0, tb_pc); advance();
    apply(1, 0, '0, 0, 0, 0, tb_pc); advance();
    check("wd_sticky", 64'(br_timeout), 64'd1);
    run_plain(2);

    // GPU stall and redirect together in HOLD, then PC wrap.
    apply(1, 0, '0, 0, 0, 1, tb_pc); advance();
    apply(1, 1, 16'h0200, 0, 0, 1, tb_pc);
    check("gpu_redir_sel", 64'(pc_sel), 64'(PC_SEL_BRANCH));
    check("gpu_redir_npc", 64'(next_pc), 64'h200);
    advance();
    check("gpu_redir_state", 64'(state), 64'(ST_RUN));
    apply(1, 0, '0, 0, 0, 0, 16'hFFFC);
    check("wrap_npc", 64'(next_pc), 64'h0);
    advance();

    // Asynchronous reset in the middle of a branch shadow.
    apply(1, 0, '0, 1, 0, 0, tb_pc); advance();
    apply(1, 0, '0, 1, 0, 0, tb_pc); advance();
    check("pre_rst_state", 64'(state), 64'(ST_BR_SHADOW));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_npc", 64'(next_pc), 64'd0);
    check("arst_sel", 64'(pc_sel), 64'd0);
    check("arst_ir", 64'(ir_hold), 64'd0);
    check("arst_valid", 64'(fe_valid), 64'd0);
    check_regs("arst");
    rst_n = 1'b1;

    // Random stimulus against the reference model.
    for (int n = 0; n < 800; n++) begin
      int r = int'($urandom_range(0, 99));
      logic [PW-1:0] cp = (r < 85) ? tb_pc : (r < 92) ? 16'hFFFC : PW'($urandom);
      apply($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 8, PW'($urandom),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 6, cp);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the Fetch stage of the GPU pipeline. Arbitrates redirect and stall sources (branch resolution from Memory; branch, dependency and GPU stalls from Decode/GPU). Each cycle it tells Fetch which next PC to load, whether to hold the IR latch, and whether the fetched word is valid. It also tracks the branch shadow, with a timeout watchdog.

## Interface
- PC_WIDTH, 16, PC and branch-target width
- BR_TIMEOUT, 15, max cycles in branch shadow before forced release (1..255)
- CNT_WIDTH, 32, performance counter width
- I_CLOCK  in  1  pipeline clock; all state updates on negedge, matching Fetch
- I_RESET_N  in  1  asynchronous, active-low reset
- I_LOCK  in  1  pipeline enable from high-level module
- I_CurPC  in  PC_WIDTH  current Fetch PC (O_PC of Fetch)
- I_BranchPC  in  PC_WIDTH  resolved branch target
- I_BranchAddrSelect  in  1  branch target valid this cycle
- I_BranchStallSignal  in  1  branch decoded, unresolved
- I_DepStallSignal  in  1  register dependency in Decode
- I_GPUStallSignal  in  1  GPU stage stall
- O_NextPC  out  PC_WIDTH  PC Fetch loads at next negedge
- O_PCSel  out  2  0=ZERO, 1=INC, 2=HOLD, 3=BRANCH
- O_IRHold  out  1  Fetch keeps current IR
- O_FE_Valid  out  1  fetched word valid to Decode
- O_State  out  3  current FSM state (debug)
- O_BranchTimeout  out  1  sticky: shadow watchdog fired
- O_StallCycles  out  CNT_WIDTH  HOLD-state cycles (see Configuration)
- O_BubbleCycles  out  CNT_WIDTH  cycles with O_FE_Valid=0 while I_LOCK=1

## Operation
- States: IDLE(0), RUN(1), HOLD(2), BR_SHADOW(3).
- Input priority each cycle: !I_LOCK > I_BranchAddrSelect > (GPU or Dep stall) > Branch stall.
- Outputs are Mealy: a combinational decode of state and current inputs.
- O_NextPC mux:
  - ZERO: 0.
  - INC: I_CurPC+4, truncated to PC_WIDTH (0xFFFC wraps to 0x0000).
  - HOLD: I_CurPC.
  - BRANCH: I_BranchPC.
- IDLE: PCSel=ZERO, IRHold=0, Valid=0. Go to RUN when I_LOCK=1.
- RUN:
  - Redirect: BRANCH, Valid=1, stay in RUN.
  - Dep/GPU stall: HOLD, IRHold=1, Valid=1, go to HOLD.
  - Branch stall alone: HOLD, Valid=0, clear shadow counter, go to BR_SHADOW.
  - Otherwise: INC, Valid=1.
- HOLD:
  - While Dep or GPU stall: HOLD, IRHold=1, Valid=1.
  - Redirect: BRANCH, Valid=1, go to RUN (redirect wins over stall).
  - Stalls clear with branch stall high: HOLD, Valid=0, go to BR_SHADOW.
  - Stalls clear otherwise: INC, Valid=1, go to RUN.
- BR_SHADOW:
  - Shadow counter increments every cycle.
  - Redirect: BRANCH, Valid=0, go to RUN.
  - Dep/GPU stall: HOLD, IRHold=1, Valid=1; counter still runs.
  - Otherwise: HOLD, Valid=0.
  - Counter reaching BR_TIMEOUT with no redirect: set O_BranchTimeout, INC, Valid=1, go to RUN.
- I_LOCK=0 in any state: IDLE outputs, next state IDLE, shadow counter cleared. O_BranchTimeout is kept.

## Timing
- Reset (async, any time) sets:
  - state=IDLE and shadow counter=0;
  - O_BranchTimeout=0, perf counters=0;
  - O_NextPC=0, O_PCSel=ZERO, O_IRHold=0, O_FE_Valid=0, O_State=0.
- Outputs are combinational on inputs, with zero-cycle latency. Fetch samples them at the same negedge that advances this FSM.
- First fetch: lock rises, and one cycle later (RUN) PCSel=INC from PC 0.
- Redirect is applied in the cycle I_BranchAddrSelect is high. There is no extra bubble in RUN or HOLD; the BR_SHADOW redirect cycle is itself a bubble.
- Simultaneous redirect and branch stall: redirect wins, next state RUN.
- Watchdog: exactly BR_TIMEOUT negedges in BR_SHADOW before forced release.
- Perf counters saturate at all-ones and never wrap.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: O_StallCycles and O_BubbleCycles count as described.
  - Undefined: no counter flops are built and both ports are tied to 0.

## Structure
- Package fetch_ctrl_pkg holds:
  - state encoding (IDLE/RUN/HOLD/BR_SHADOW);
  - PCSel encoding (ZERO/INC/HOLD/BRANCH);
  - PC_INC=4.
- Sub-module fetch_sat_counter: parameterised-width saturating counter with enable and async active-low clear. It is instantiated twice, only under FETCH_PERF_CNT_EN.

## Test plan
- Reset then I_LOCK=1, no stalls, I_CurPC following O_NextPC → PCSel INC; NextPC sequence 0x0004, 0x0008, 0x000C; Valid=1.
- Dep stall for 3 cycles at PC 0x0010 → 3 cycles of HOLD with IRHold=1, Valid=1, NextPC=0x0010; next cycle NextPC=0x0014, state RUN.
- Branch stall at PC 0x0020, I_BranchAddrSelect with 0x0100 four cycles later → 3 bubbles at Valid=0, then NextPC=0x0100 with PCSel BRANCH; BubbleCycles=4 with FETCH_PERF_CNT_EN.
- Branch stall held BR_TIMEOUT=15 cycles with no redirect → O_BranchTimeout=1 on the 15th negedge, PCSel INC, state RUN; flag stays set after I_LOCK toggles.
- GPU stall plus I_BranchAddrSelect (0x0200) in the same cycle in HOLD → PCSel BRANCH, next state RUN; I_CurPC=0xFFFC in RUN → NextPC=0x0000.
- I_RESET_N pulsed low mid-BR_SHADOW, between edges → all outputs and counters read 0 immediately, state IDLE.
